// File: rtl/oneshot_playback_memory.sv
// One-shot playback memory: host loads ADC-format words while idle, then streams them from address 0
// once (or looping) at one word per clock in place of the ADC array.
module oneshot_playback_memory #(
   parameter int Nadc        = 8,
   parameter int N_lanes     = 18,
   parameter int N_mem_addr  = 10,
   parameter int N_mem_tiles = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [N_lanes*Nadc-1:0]              in_data,
   input  logic [N_mem_addr+$clog2(N_mem_tiles)-1:0] in_addr,
   input  logic                                 in_write,
   input  logic                                 in_start_play,
   input  logic                                 in_loop,
   input  logic [N_mem_addr+$clog2(N_mem_tiles)-1:0] in_play_len,
   output logic [N_lanes*Nadc-1:0]              out_data,
   output logic                                 out_valid,
   output logic                                 out_done,
   output logic [1:0]                           out_state
);
   localparam int TW   = $clog2(N_mem_tiles);
   localparam int AW   = N_mem_addr + TW;
   localparam int W    = N_lanes * Nadc;
   localparam int ROWS = 2 ** N_mem_addr;

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_t;

   state_t          state;
   logic [AW-1:0]   ptr;
   logic [AW-1:0]   last;
   logic            loop_q;
   logic [W-1:0]    mem [N_mem_tiles][ROWS];

   logic [TW-1:0]          wr_tile, rd_tile;
   logic [N_mem_addr-1:0]  wr_row, rd_row;

   assign wr_tile   = in_addr[AW-1:N_mem_addr];
   assign wr_row    = in_addr[N_mem_addr-1:0];
   assign rd_tile   = ptr[AW-1:N_mem_addr];
   assign rd_row    = ptr[N_mem_addr-1:0];
   assign out_state = state;

   // Storage is deliberately not reset so recorded traces survive rst.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_write)
         mem[wr_tile][wr_row] <= in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         last      <= '0;
         loop_q    <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               out_data  <= '0;
               out_valid <= 1'b0;
               out_done  <= 1'b0;
               if (in_start_play) begin
                  state  <= PLAY;
                  ptr    <= '0;
                  // len 0 wraps to D-1, i.e. a full-depth playback
                  last   <= in_play_len - AW'(1);
                  loop_q <= in_loop;
               end
            end
            PLAY: begin
               if (!in_start_play) begin
                  state     <= IDLE;
                  ptr       <= '0;
                  out_data  <= '0;
                  out_valid <= 1'b0;
               end else begin
                  out_data  <= mem[rd_tile][rd_row];
                  out_valid <= 1'b1;
                  if (ptr == last) begin
                     ptr <= '0;
                     if (!loop_q) begin
                        state    <= DONE;
                        out_done <= 1'b1;
                     end
                  end else begin
                     ptr <= ptr + AW'(1);
                  end
               end
            end
            DONE: begin
               out_data  <= '0;
               out_valid <= 1'b0;
               if (!in_start_play) begin
                  state    <= IDLE;
                  out_done <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_data  <= '0;
               out_valid <= 1'b0;
               out_done  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_oneshot_playback_memory.sv
// Directed + randomized bench for oneshot_playback_memory against a word-index reference model.
module tb_oneshot_playback_memory;
   localparam int NADC = 8;
   localparam int NL   = 18;
   localparam int AW   = 12;
   localparam int D    = 4096;
   localparam int W    = NADC * NL;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic [AW-1:0] in_addr = '0;
   logic          in_write = 1'b0;
   logic          in_start_play = 1'b0;
   logic          in_loop = 1'b0;
   logic [AW-1:0] in_play_len = '0;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_done;
   logic [1:0]    out_state;

   int n_cmp = 0;
   int n_bad = 0;
   logic [W-1:0] ref_mem [D];

   oneshot_playback_memory dut (
      .clk           (clk),
      .rst           (rst),
      .in_data       (in_data),
      .in_addr       (in_addr),
      .in_write      (in_write),
      .in_start_play (in_start_play),
      .in_loop       (in_loop),
      .in_play_len   (in_play_len),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_done      (out_done),
      .out_state     (out_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] pat(input int a);
      logic [W-1:0] w;
      for (int i = 0; i < NL; i++) w[i*NADC +: NADC] = NADC'((a + i) % 128);
      return w;
   endfunction

   function automatic logic [W-1:0] fill(input logic [NADC-1:0] v);
      logic [W-1:0] w;
      for (int i = 0; i < NL; i++) w[i*NADC +: NADC] = v;
      return w;
   endfunction

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] w;
      for (int i = 0; i < NL; i++) w[i*NADC +: NADC] = NADC'($urandom);
      return w;
   endfunction

   task automatic write_word(input int a, input logic [W-1:0] d);
      in_write = 1'b1;
      in_addr  = AW'(a);
      in_data  = d;
      tick();
      in_write = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_state"}, W'(out_state), W'(0));
      chk({tag, "_valid"}, W'(out_valid), W'(0));
      chk({tag, "_data"},  out_data,       '0);
      chk({tag, "_done"},  W'(out_done),  W'(0));
   endtask

   // Holds start for `hold` edges (edge 1 is the start edge). Word n is expected after edge n+2.
   // A write pulsed before edge wr_tick only lands when that edge is the start edge (still IDLE).
   task automatic run_play(input int len_field, input bit lp, input int hold, input bit rel,
                           input int wr_tick, input int wr_addr, input logic [W-1:0] wr_data,
                           output int nvalid);
      int L, n;
      logic ev, edone, cdone;
      logic [1:0] es;
      logic [W-1:0] ed;
      L = (len_field == 0) ? D : len_field;
      nvalid = 0;
      in_play_len   = AW'(len_field);
      in_loop       = lp;
      in_start_play = 1'b1;
      for (int j = 1; j <= hold; j++) begin
         if (j == wr_tick) begin
            in_write = 1'b1;
            in_addr  = AW'(wr_addr);
            in_data  = wr_data;
            if (j == 1) ref_mem[wr_addr] = wr_data;
         end
         tick();
         in_write = 1'b0;
         // Length and loop are latched at start; later changes must be ignored.
         in_play_len = AW'($urandom);
         in_loop     = 1'($urandom);
         if (j == 1) begin
            ev = 1'b0; ed = '0; es = 2'd1; edone = 1'b0; cdone = 1'b1;
         end else begin
            n = j - 2;
            if (lp || n < L) begin
               ev = 1'b1; ed = ref_mem[n % L];
               es = (!lp && n == L - 1) ? 2'd2 : 2'd1;
               edone = 1'b0; cdone = (es == 2'd1);
            end else begin
               ev = 1'b0; ed = '0; es = 2'd2; edone = 1'b1; cdone = 1'b1;
            end
         end
         if (out_valid === 1'b1) nvalid++;
         chk($sformatf("play_valid j=%0d", j), W'(out_valid), W'(ev));
         chk($sformatf("play_data j=%0d", j),  out_data,       ed);
         chk($sformatf("play_state j=%0d", j), W'(out_state), W'(es));
         if (cdone) chk($sformatf("play_done j=%0d", j), W'(out_done), W'(edone));
      end
      if (rel) begin
         in_start_play = 1'b0;
         tick();
         chk_idle("release");
         tick();
         chk_idle("release_settle");
      end
   endtask

   initial begin
      int nv;
      int len, hold, nw;
      #3 rst = 1'b1;
      #2;
      chk_idle("reset");
      tick();
      rst = 1'b0;
      tick();
      chk_idle("post_reset");

      // Full-depth one-shot
      for (int a = 0; a < D; a++) write_word(a, pat(a));
      run_play(0, 1'b0, D + 3, 1'b1, -1, 0, '0, nv);
      chk("full_word_count", W'(nv), W'(D));

      // Looping short stream
      run_play(5, 1'b1, 20, 1'b1, -1, 0, '0, nv);
      chk("loop_word_count", W'(nv), W'(19));

      // Abort right after word 30
      run_play(100, 1'b0, 32, 1'b0, -1, 0, '0, nv);
      in_start_play = 1'b0;
      nw = 0;
      for (int j = 0; j < 6; j++) begin
         tick();
         if (out_valid === 1'b1) nw++;
         chk($sformatf("abort_idle k=%0d", j), W'(out_state), W'(0));
         chk($sformatf("abort_data k=%0d", j), out_data, '0);
      end
      chk("abort_extra_words", W'(nw), W'(0));
      chk("abort_word_count", W'(nv), W'(31));

      // Write during PLAY is ignored; write in IDLE is seen
      write_word(2, fill(8'd7));
      run_play(4, 1'b0, 8, 1'b1, 3, 2, fill(8'hFF), nv);
      write_word(2, fill(8'hFF));
      run_play(4, 1'b0, 8, 1'b1, -1, 0, '0, nv);

      // Async reset mid-stream, memory retained
      run_play(50, 1'b0, 12, 1'b0, -1, 0, '0, nv);
      #2 rst = 1'b1;
      #1;
      chk_idle("midplay_reset");
      in_start_play = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk_idle("after_reset");
      run_play(3, 1'b0, 7, 1'b1, -1, 0, '0, nv);
      chk("replay_word_count", W'(nv), W'(3));

      // Same-edge write and start
      run_play(1, 1'b0, 5, 1'b1, 1, 0, fill(8'd55), nv);
      chk("sameedge_word_count", W'(nv), W'(1));

      // Randomized sessions
      for (int it = 0; it < 8; it++) begin
         for (int k = 0; k < 6; k++) write_word($urandom_range(0, 63), rnd_word());
         len  = $urandom_range(1, 64);
         hold = $urandom_range(1, 80);
         run_play(len, 1'($urandom), hold, 1'b1, $urandom_range(1, 10),
                  $urandom_range(0, 63), rnd_word(), nv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
